// File: rtl/sme_job_sched_if.sv
// Host load port, SME character port and result port of the SME job scheduler.
// master is the host/SME side, slave is the scheduler itself.
interface sme_job_sched_if #(
  parameter int NPAT = 4
);
  logic            ld_valid;
  logic            ld_type;
  logic            ld_last;
  logic [7:0]      ld_data;
  logic            ld_ready;
  logic            go;
  logic [7:0]      sme_chardata;
  logic            sme_isstring;
  logic            sme_ispattern;
  logic            sme_valid;
  logic            sme_match;
  logic [4:0]      sme_match_index;
  logic            res_valid;
  logic [2:0]      res_id;
  logic            res_match;
  logic [4:0]      res_index;
  logic            done;
  logic [NPAT-1:0] match_vec;
  logic            busy;
  logic            err;

  modport master (
    output ld_valid, ld_type, ld_last, ld_data, go,
    output sme_valid, sme_match, sme_match_index,
    input  ld_ready, sme_chardata, sme_isstring, sme_ispattern,
    input  res_valid, res_id, res_match, res_index, done, match_vec, busy, err
  );

  modport slave (
    input  ld_valid, ld_type, ld_last, ld_data, go,
    input  sme_valid, sme_match, sme_match_index,
    output ld_ready, sme_chardata, sme_isstring, sme_ispattern,
    output res_valid, res_id, res_match, res_index, done, match_vec, busy, err
  );
endinterface

// File: rtl/sme_job_sched.sv
// Replays the loaded string plus one pattern per step into the SME and collects verdicts.
// go -> first SME strobe in 1 cycle; ld_ready drops for the whole job, so host loads stall.
module sme_job_sched #(
  parameter int NPAT = 4,
  parameter int SLEN = 32,
  parameter int PLEN = 8,
  parameter int TMO  = 255
) (
  input logic            clk,
  input logic            reset_n,
  sme_job_sched_if.slave bus
);
  localparam int SW  = $clog2(SLEN + 1);
  localparam int SIW = $clog2(SLEN);
  localparam int PW  = $clog2(PLEN + 1);
  localparam int PIW = $clog2(PLEN);
  localparam int NW  = $clog2(NPAT + 1);
  localparam int KW  = (NPAT > 1) ? $clog2(NPAT) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SEND_S, SEND_P, WAIT, NEXT, FIN} state_t;

  state_t          state, state_n;
  logic [SW-1:0]   cnt, cnt_n;
  logic [2:0]      k, k_n;
  logic [7:0]      str_buf [SLEN];
  logic [7:0]      pat_buf [NPAT][PLEN];
  logic [SW-1:0]   slen;
  logic [PW-1:0]   plen [NPAT];
  logic [NW-1:0]   npat;
  logic [7:0]      tmo_cnt;
  logic            cap_match;
  logic [4:0]      cap_index;
  logic [NPAT-1:0] match_vec;
  logic            err;
  logic [7:0]      chardata_q, chardata_n;
  logic            isstring_q, isstring_n;
  logic            ispattern_q, ispattern_n;

  logic            ld_ready, go_ok, ld_acc, job_empty, timeout;
  logic [KW-1:0]   kidx, kidx_n, widx;
  logic [PW-1:0]   plen_k;

  assign ld_ready  = (state == IDLE) || (state == LOAD);
  assign go_ok     = bus.go && ld_ready;
  assign ld_acc    = bus.ld_valid && ld_ready && !bus.go;
  assign job_empty = (slen == '0) || (npat == '0);
  assign kidx      = k[KW-1:0];
  assign kidx_n    = k_n[KW-1:0];
  assign widx      = npat[KW-1:0];
  assign plen_k    = plen[kidx];
  assign timeout   = (state == WAIT) && !bus.sme_valid && (tmo_cnt == 8'(TMO - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      k     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      k     <= k_n;
    end
  end

  // State and cnt describe the cycle after the edge, so the SME strobes are registered
  // from the next-state view and go reaches the SME one cycle later.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    k_n         = k;
    isstring_n  = 1'b0;
    ispattern_n = 1'b0;
    chardata_n  = 8'd0;
    unique case (state)
      IDLE, LOAD: begin
        if (bus.go) begin
          k_n   = '0;
          cnt_n = '0;
          if (job_empty) begin
            state_n = FIN;
          end else begin
            state_n = SEND_S;
          end
        end else if (bus.ld_valid) begin
          state_n = LOAD;
        end
      end
      SEND_S: begin
        if (cnt == slen - SW'(1)) begin
          cnt_n   = '0;
          state_n = (plen_k == '0) ? WAIT : SEND_P;
        end else begin
          cnt_n = cnt + SW'(1);
        end
      end
      SEND_P: begin
        if (cnt == SW'(plen_k) - SW'(1)) begin
          cnt_n   = '0;
          state_n = WAIT;
        end else begin
          cnt_n = cnt + SW'(1);
        end
      end
      WAIT: begin
        if (bus.sme_valid || timeout) begin
          state_n = NEXT;
        end
      end
      NEXT: begin
        if (4'(k) + 4'd1 < 4'(npat)) begin
          k_n     = k + 3'd1;
          cnt_n   = '0;
          state_n = SEND_S;
        end else begin
          state_n = FIN;
        end
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (state_n == SEND_S) begin
      isstring_n = 1'b1;
      chardata_n = str_buf[cnt_n[SIW-1:0]];
    end else if (state_n == SEND_P) begin
      ispattern_n = 1'b1;
      chardata_n  = pat_buf[kidx_n][cnt_n[PIW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chardata_q  <= 8'd0;
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
      slen        <= '0;
      npat        <= '0;
      tmo_cnt     <= 8'd0;
      cap_match   <= 1'b0;
      cap_index   <= 5'd0;
      match_vec   <= '0;
      err         <= 1'b0;
      for (int i = 0; i < SLEN; i++) begin
        str_buf[i] <= 8'd0;
      end
      for (int p = 0; p < NPAT; p++) begin
        plen[p] <= '0;
        for (int j = 0; j < PLEN; j++) begin
          pat_buf[p][j] <= 8'd0;
        end
      end
    end else begin
      chardata_q  <= chardata_n;
      isstring_q  <= isstring_n;
      ispattern_q <= ispattern_n;
      tmo_cnt     <= (state == WAIT) ? tmo_cnt + 8'd1 : 8'd0;

      if (go_ok) begin
        err       <= 1'b0;
        match_vec <= '0;
      end else if (ld_acc) begin
        if (!bus.ld_type) begin
          if (slen < SW'(SLEN)) begin
            str_buf[slen[SIW-1:0]] <= bus.ld_data;
            slen                   <= slen + SW'(1);
          end else begin
            err <= 1'b1;
          end
        end else if (npat < NW'(NPAT)) begin
          if (plen[widx] < PW'(PLEN)) begin
            pat_buf[widx][plen[widx][PIW-1:0]] <= bus.ld_data;
            plen[widx]                         <= plen[widx] + PW'(1);
          end else begin
            err <= 1'b1;
          end
          if (bus.ld_last) begin
            npat <= npat + NW'(1);
          end
        end else begin
          err <= 1'b1;
        end
      end

      // Capture on the WAIT exit edge so match_vec and res_valid appear together in NEXT.
      if (state == WAIT) begin
        if (bus.sme_valid) begin
          cap_match       <= bus.sme_match;
          cap_index       <= bus.sme_match_index;
          match_vec[kidx] <= bus.sme_match;
        end else if (timeout) begin
          cap_match       <= 1'b0;
          cap_index       <= 5'd0;
          match_vec[kidx] <= 1'b0;
          err             <= 1'b1;
        end
      end

      if (state == FIN) begin
        slen <= '0;
        npat <= '0;
        for (int p = 0; p < NPAT; p++) begin
          plen[p] <= '0;
        end
      end
    end
  end

  assign bus.ld_ready      = ld_ready;
  assign bus.sme_chardata  = chardata_q;
  assign bus.sme_isstring  = isstring_q;
  assign bus.sme_ispattern = ispattern_q;
  assign bus.res_valid     = (state == NEXT);
  assign bus.res_id        = (state == NEXT) ? k : 3'd0;
  assign bus.res_match     = (state == NEXT) && cap_match;
  assign bus.res_index     = ((state == NEXT) && cap_match) ? cap_index : 5'd0;
  assign bus.done          = (state == FIN);
  assign bus.match_vec     = match_vec;
  assign bus.busy          = (state == SEND_S) || (state == SEND_P) ||
                             (state == WAIT) || (state == NEXT);
  assign bus.err           = err;

endmodule

// File: tb/tb_sme_job_sched.sv
// Directed bench for sme_job_sched with a behavioural SME (substring search, '^' anchors at 0).
module tb_sme_job_sched;
  localparam int NPAT = 4;
  localparam int TMO  = 255;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sme_job_sched_if #(.NPAT(NPAT)) bus ();

  sme_job_sched #(.NPAT(NPAT), .SLEN(32), .PLEN(8), .TMO(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;
  int go_cyc;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: strobe runs, results and done pulses, all stamped with the cycle number.
  int s_cnt = 0, p_cnt = 0, done_cnt = 0, done_cyc = 0;
  int s_starts[$], p_starts[$], r_id[$], r_m[$], r_ix[$], r_cyc[$];
  logic prev_s = 1'b0, prev_p = 1'b0;

  always @(negedge clk) begin
    if (bus.sme_isstring) begin
      s_cnt++;
      if (!prev_s) s_starts.push_back(cyc);
    end
    if (bus.sme_ispattern) begin
      p_cnt++;
      if (!prev_p) p_starts.push_back(cyc);
    end
    prev_s = bus.sme_isstring;
    prev_p = bus.sme_ispattern;
    if (bus.res_valid) begin
      r_id.push_back(int'(bus.res_id));
      r_m.push_back(int'(bus.res_match));
      r_ix.push_back(int'(bus.res_index));
      r_cyc.push_back(cyc);
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // SME model: collects string/pattern, answers 3 cycles after the pattern ends.
  logic       silent = 1'b0;
  logic [7:0] m_str [64];
  logic [7:0] m_pat [64];
  int         m_slen = 0, m_plen = 0, cd = 0, pend_idx = -1;
  logic       in_pat = 1'b0, prev_ms = 1'b0;
  int         vld_cyc[$];

  function automatic int find_pat();
    int  off, body;
    logic ok;
    if (m_plen == 0) return -1;
    off  = (m_pat[0] == 8'h5e) ? 1 : 0;
    body = m_plen - off;
    for (int p = 0; p + body <= m_slen; p++) begin
      if (off == 1 && p != 0) break;
      ok = 1'b1;
      for (int j = 0; j < body; j++) begin
        if (m_str[p + j] != m_pat[off + j]) ok = 1'b0;
      end
      if (ok) return p;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      cd                  = 0;
      in_pat              = 1'b0;
      prev_ms             = 1'b0;
      m_slen              = 0;
      m_plen              = 0;
      bus.sme_valid       = 1'b0;
      bus.sme_match       = 1'b0;
      bus.sme_match_index = 5'd0;
    end else begin
      bus.sme_valid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.sme_valid       = 1'b1;
          bus.sme_match       = (pend_idx >= 0);
          bus.sme_match_index = (pend_idx >= 0) ? 5'(pend_idx) : 5'd0;
          vld_cyc.push_back(cyc);
        end
      end
      if (bus.sme_isstring) begin
        if (!prev_ms) m_slen = 0;
        if (m_slen < 64) begin
          m_str[m_slen] = bus.sme_chardata;
          m_slen++;
        end
      end
      prev_ms = bus.sme_isstring;
      if (bus.sme_ispattern) begin
        if (!in_pat) m_plen = 0;
        if (m_plen < 64) begin
          m_pat[m_plen] = bus.sme_chardata;
          m_plen++;
        end
        in_pat = 1'b1;
      end else if (in_pat) begin
        in_pat   = 1'b0;
        pend_idx = find_pat();
        if (!silent) cd = 3;
      end
    end
  end

  task automatic send_char(input logic t, input logic last, input logic [7:0] d);
    @(negedge clk);
    bus.ld_valid = 1'b1;
    bus.ld_type  = t;
    bus.ld_last  = last;
    bus.ld_data  = d;
  endtask

  task automatic idle_ld();
    @(negedge clk);
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(1'b0, 1'b0, s[i]);
  endtask

  task automatic load_pat(input string s);
    for (int i = 0; i < s.len(); i++) send_char(1'b1, (i == s.len() - 1), s[i]);
  endtask

  task automatic do_go();
    @(negedge clk);
    bus.go = 1'b1;
    go_cyc = cyc;
    @(negedge clk);
    bus.go = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    logic seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, seen, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_res(input string tag, input int i, input int id, input int m, input int ix);
    if (i < r_id.size()) begin
      chk({tag, "_id"}, r_id[i], id);
      chk({tag, "_match"}, r_m[i], m);
      chk({tag, "_index"}, r_ix[i], ix);
    end else begin
      chk({tag, "_present"}, r_id.size(), i + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int br, bd, bs, bp, bv, sc, pc;
    logic seen;
    bus.ld_valid = 1'b0;
    bus.ld_type  = 1'b0;
    bus.ld_last  = 1'b0;
    bus.ld_data  = 8'd0;
    bus.go       = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ld_ready", bus.ld_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done_res", {bus.done, bus.res_valid, bus.res_match, bus.res_id, bus.res_index}, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_mvec", bus.match_vec, 0);
    chk("rst_sme", {bus.sme_isstring, bus.sme_ispattern, bus.sme_chardata}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // A: "ab cd" against "cd", "^ab", "x"
    load_str("ab cd"); load_pat("cd"); load_pat("^ab"); load_pat("x"); idle_ld();
    br = r_id.size(); bd = done_cnt;
    do_go();
    wait_done("A", 2000);
    chk("A_nres", r_id.size() - br, 3);
    chk_res("A0", br, 0, 1, 3);
    chk_res("A1", br + 1, 1, 1, 0);
    chk_res("A2", br + 2, 2, 0, 0);
    chk("A_mvec", bus.match_vec, 4'b0011);
    chk("A_err", bus.err, 0);
    chk("A_done_once", done_cnt - bd, 1);
    chk("A_busy_after", bus.busy, 0);

    // B: strobe timing, 5-char string, two 2-char patterns
    load_str("hello"); load_pat("ll"); load_pat("lo"); idle_ld();
    br = r_id.size(); bs = s_starts.size(); bp = p_starts.size();
    bv = vld_cyc.size(); sc = s_cnt; pc = p_cnt;
    do_go();
    wait_done("B", 2000);
    chk("B_scnt", s_cnt - sc, 10);
    chk("B_pcnt", p_cnt - pc, 4);
    chk("B_pruns", p_starts.size() - bp, 2);
    chk("B_go_lat", s_starts[bs], go_cyc + 1);
    chk("B_nogap0", p_starts[bp], s_starts[bs] + 5);
    chk("B_restart", s_starts[bs + 1], vld_cyc[bv] + 2);
    chk("B_nogap1", p_starts[bp + 1], s_starts[bs + 1] + 5);
    chk("B_res_lat", r_cyc[br], vld_cyc[bv] + 1);
    chk("B_done_lat", done_cyc, r_cyc[br + 1] + 1);
    chk_res("B0", br, 0, 1, 2);
    chk_res("B1", br + 1, 1, 1, 3);

    // C: SME never answers
    silent = 1'b1;
    load_str("abc"); load_pat("a"); load_pat("b"); idle_ld();
    br = r_id.size(); bp = p_starts.size();
    do_go();
    wait_done("C", 2000);
    chk("C_nres", r_id.size() - br, 2);
    chk("C_tmo_lat", r_cyc[br], p_starts[bp] + TMO + 1);
    chk_res("C0", br, 0, 0, 0);
    chk_res("C1", br + 1, 1, 0, 0);
    chk("C_err", bus.err, 1);
    chk("C_mvec", bus.match_vec, 0);

    // D: string and pattern overflow, go clears err
    silent = 1'b0;
    load_str("0123456789abcdefghijklmnopqrstuvwx"); load_pat("mnopqrst9"); idle_ld();
    chk("D_err_load", bus.err, 1);
    br = r_id.size(); sc = s_cnt; pc = p_cnt;
    do_go();
    chk("D_err_go", bus.err, 0);
    chk("D_busy", bus.busy, 1);
    chk("D_ld_ready", bus.ld_ready, 0);
    wait_done("D", 3000);
    chk("D_scnt", s_cnt - sc, 32);
    chk("D_pcnt", p_cnt - pc, 8);
    chk_res("D0", br, 0, 1, 22);
    chk("D_err_end", bus.err, 0);
    chk("D_mvec", bus.match_vec, 4'b0001);

    // E: go with a string but no patterns
    load_str("ab"); idle_ld();
    br = r_id.size(); sc = s_cnt; pc = p_cnt;
    do_go();
    wait_done("E", 10);
    chk("E_done_lat", done_cyc, go_cyc + 1);
    chk("E_mvec", bus.match_vec, 0);
    chk("E_strobes", (s_cnt - sc) + (p_cnt - pc), 0);
    chk("E_nres", r_id.size() - br, 0);

    // F: reset during SEND_P, then a clean job
    load_str("abcd"); load_pat("cd"); idle_ld();
    do_go();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.sme_ispattern) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("F_in_sendp", seen, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("F_rst_strobes", {bus.sme_isstring, bus.sme_ispattern}, 0);
    chk("F_rst_busy", bus.busy, 0);
    chk("F_rst_ld_ready", bus.ld_ready, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    load_str("abcd"); load_pat("bc"); idle_ld();
    br = r_id.size();
    do_go();
    wait_done("F", 2000);
    chk("F_nres", r_id.size() - br, 1);
    chk_res("F0", br, 0, 1, 1);
    chk("F_mvec", bus.match_vec, 4'b0001);
    chk("F_err", bus.err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sme_job_sched.md
# sme_job_sched

Job scheduler that sequences the string-matching engine (SME). A host loads one string and up to NPAT patterns into local buffers. On `go`, the scheduler replays the string and then one pattern into the SME for each pattern in turn, waits for the SME verdict, and reports a per-pattern result plus a final match vector. It sits between the host load port and the SME character port, and it is the only driver of `isstring`/`ispattern`.

## Interface
- NPAT, 4: maximum patterns per job (1..8)
- SLEN, 32: string buffer depth in characters
- PLEN, 8: pattern buffer depth in characters
- TMO, 255: cycles allowed in WAIT before timeout (8-bit counter)

- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- ld_valid  in  1  host character strobe
- ld_type  in  1  0 = string char, 1 = pattern char
- ld_last  in  1  with pattern char: this char ends the current pattern
- ld_data  in  8  character
- ld_ready  out  1  high in IDLE and LOAD; low otherwise
- go  in  1  one-cycle start pulse; sampled only in IDLE/LOAD
- sme_chardata  out  8  character to SME
- sme_isstring  out  1  string strobe to SME
- sme_ispattern  out  1  pattern strobe to SME
- sme_valid  in  1  SME verdict strobe
- sme_match  in  1  SME match flag
- sme_match_index  in  5  SME match position
- res_valid  out  1  one-cycle pulse per finished pattern
- res_id  out  3  pattern number of the current res_valid
- res_match  out  1  verdict (forced 0 on timeout)
- res_index  out  5  match index (0 when res_match = 0)
- done  out  1  one-cycle pulse at job end
- match_vec  out  NPAT  bit k = res_match of pattern k; held until next go
- busy  out  1  high from go acceptance until done
- err  out  1  sticky: overflow or timeout; cleared by go

## Operation
- States: IDLE, LOAD, SEND_S, SEND_P, WAIT, NEXT, FIN.
- Load:
  - Accepted chars are written at slen (string) or plen[npat] (pattern).
  - ld_last increments npat and starts the next pattern buffer.
  - IDLE → LOAD on the first accepted char.
  - Chars beyond SLEN/PLEN, or patterns beyond NPAT, are dropped and set err.
- go with slen = 0 or npat = 0 → FIN directly; done fires with match_vec = 0.
- Otherwise: busy = 1, k = 0, err cleared, → SEND_S.
- SEND_S: drives string chars 0..slen-1 with sme_isstring = 1, one per cycle.
- SEND_P:
  - Begins the cycle immediately after the last string char, with no gap. The SME treats an idle cycle as an empty pattern.
  - Drives pattern k chars 0..plen[k]-1 with sme_ispattern = 1.
  - Then → WAIT.
- WAIT:
  - sme_valid = 1: capture sme_match and sme_match_index → NEXT.
  - Counter reaches TMO first: capture match 0, set err → NEXT.
- NEXT:
  - Pulse res_valid and write match_vec[k]. match_vec bits at and above npat read 0.
  - k+1 < npat → k++, → SEND_S. The string is re-sent for every pattern.
  - Otherwise → FIN.
- FIN: pulse done, busy = 0, clear slen/npat/plen, → IDLE. match_vec and err are held.
- go while busy: ignored. ld_valid while busy: ignored, not an error.
- sme_valid outside WAIT: ignored.
- All SME outputs are registered. sme_chardata = 0 whenever both strobes are low.

## Timing
- Reset (async assert, sync release): state IDLE; every output 0 except ld_ready = 1; buffers, counters, match_vec and err cleared.
- Reset mid-job drops the strobes immediately. The SME must be reset together with this block.
- Latency go → first sme_isstring: 1 cycle.
- Per pattern: slen + plen[k] strobe cycles, then WAIT, then 1 NEXT cycle.
  - The next SEND_S begins the cycle after NEXT, so strobes restart 2 cycles after sme_valid.
  - This lets the SME pass through DONE and IDLE.
- res_valid fires 1 cycle after sme_valid is sampled.
- done fires 1 cycle after the last res_valid.
- Timeout: res_valid fires TMO+1 cycles after the last pattern strobe.

## Test plan
- String "ab cd", patterns "cd", "^ab", "x", go → three res_valid: (0,1,3), (1,1,0), (2,0,0); match_vec = 0b011; err = 0; done once.
- Strobe trace, 5-char string + 2-char pattern → isstring high exactly 5 cycles, ispattern high exactly 2 consecutive cycles with no gap; the second job's isstring restarts exactly 2 cycles after sme_valid.
- SME model never raises valid → res_match = 0 after TMO+1 cycles, err = 1, job continues to the next pattern; the next go clears err.
- 34 string chars and a 9-char pattern loaded → err = 1 at load; SME receives only 32 and 8 chars.
- go with no patterns loaded → done 1 cycle later, match_vec = 0, no SME strobes.
- reset_n pulsed low during SEND_P → strobes low the same cycle, busy = 0, ld_ready = 1; a full job after release completes normally.
